// File: rtl/lc3b_fetch_buffer_pkg.sv
// Shared LC-3b types plus the fetch-stage FSM state and FIFO entry layout.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [3:0] {
      op_br   = 4'b0000, op_add  = 4'b0001, op_ldb  = 4'b0010, op_stb  = 4'b0011,
      op_jsr  = 4'b0100, op_and  = 4'b0101, op_ldr  = 4'b0110, op_str  = 4'b0111,
      op_rti  = 4'b1000, op_not  = 4'b1001, op_ldi  = 4'b1010, op_sti  = 4'b1011,
      op_jmp  = 4'b1100, op_shf  = 4'b1101, op_lea  = 4'b1110, op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [1:0] {
      fetch_idle,
      fetch_busy,
      fetch_drop
   } lc3b_fetch_state;

   typedef struct packed {
      lc3b_word inst;
      lc3b_word pc;
   } lc3b_fetch_entry;

   function automatic lc3b_word pc_align(input lc3b_word a);
      return a & 16'hFFFE;
   endfunction

endpackage

// File: rtl/lc3b_fetch_buffer_fifo.sv
// Circular instruction buffer: DEPTH entries (power of two), synchronous flush.
module lc3b_fetch_fifo
   import lc3b_types::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  lc3b_fetch_entry            wdata_i,
   output lc3b_fetch_entry            rdata_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   lc3b_fetch_entry mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (count_q != CW'(DEPTH));

   // Storage is cleared on reset so the head outputs read as zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/lc3b_fetch_buffer.sv
// LC-3b instruction prefetch: single-outstanding memory reads into a small FIFO.
// Define LC3B_FETCH_BYPASS_EN to forward a response straight to an empty head.
module lc3b_fetch_buffer
   import lc3b_types::*;
#(
   parameter int       DEPTH    = 2,
   parameter lc3b_word RESET_PC = 16'h0000
) (
   input  logic       clk,
   input  logic       reset_n,
   output lc3b_word   mem_address,
   output logic       mem_read,
   input  logic       mem_resp,
   input  lc3b_word   mem_rdata,
   input  logic       redirect,
   input  lc3b_word   redirect_pc,
   output logic       inst_valid,
   output lc3b_word   inst,
   output lc3b_word   inst_pc,
   output lc3b_opcode inst_opcode,
   input  logic       inst_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   lc3b_fetch_state state_q, state_d;
   lc3b_word        fetch_pc_q, fetch_pc_d;
   lc3b_word        stale_q, stale_d;

   logic            push, fifo_pop, fifo_empty, byp_act, byp_take;
   logic [CW-1:0]   fifo_count;
   lc3b_fetch_entry fifo_head, head;

   lc3b_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (redirect),
      .push_i  (push),
      .pop_i   (fifo_pop),
      .wdata_i ('{inst: mem_rdata, pc: fetch_pc_q}),
      .rdata_o (fifo_head),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

`ifdef LC3B_FETCH_BYPASS_EN
   assign byp_act = (state_q == fetch_busy) && mem_resp && !redirect && fifo_empty;
`else
   assign byp_act = 1'b0;
`endif
   assign byp_take = byp_act && inst_ready;

   // A redirect flushes the FIFO, so it also swallows any pop this cycle.
   assign fifo_pop    = !fifo_empty && inst_ready && !redirect;
   assign head        = byp_act ? '{inst: mem_rdata, pc: fetch_pc_q} : fifo_head;
   assign inst_valid  = !fifo_empty || byp_act;
   assign inst        = head.inst;
   assign inst_pc     = head.pc;
   assign inst_opcode = lc3b_opcode'(head.inst[15:12]);

   assign mem_read    = (state_q != fetch_idle);
   assign mem_address = (state_q == fetch_drop) ? stale_q : fetch_pc_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      stale_d    = stale_q;
      push       = 1'b0;
      unique case (state_q)
         fetch_idle:
            if (!redirect && fifo_count < CW'(DEPTH)) state_d = fetch_busy;
         fetch_busy:
            if (mem_resp) begin
               state_d = fetch_idle;
               if (!redirect) begin
                  push       = !byp_take;
                  fetch_pc_d = fetch_pc_q + 16'd2;
               end
            end else if (redirect) begin
               // Keep presenting the old address until memory answers.
               state_d = fetch_drop;
               stale_d = fetch_pc_q;
            end
         fetch_drop:
            if (mem_resp) state_d = fetch_idle;
         default: state_d = fetch_idle;
      endcase
      if (redirect) fetch_pc_d = pc_align(redirect_pc);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= fetch_idle;
         fetch_pc_q <= pc_align(RESET_PC);
         stale_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         stale_q    <= stale_d;
      end
   end

endmodule

// File: tb/tb_lc3b_fetch_buffer.sv
// Directed plus randomized bench for lc3b_fetch_buffer against a queue-based model.
module tb_lc3b_fetch_buffer;
   import lc3b_types::*;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   lc3b_word   mem_address, mem_rdata = '0, redirect_pc = '0, inst, inst_pc;
   logic       mem_read, mem_resp = 1'b0, redirect = 1'b0, inst_valid, inst_ready = 1'b0;
   lc3b_opcode inst_opcode;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Reference model: buffered words, outstanding request, and whether it is stale.
   lc3b_word mq_inst[$];
   lc3b_word mq_pc[$];
   bit       m_out = 1'b0, m_stale = 1'b0;
   lc3b_word m_req = '0, m_pc = 16'h3000;

   lc3b_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(16'h3000)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mem_address (mem_address),
      .mem_read    (mem_read),
      .mem_resp    (mem_resp),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_opcode (inst_opcode),
      .inst_ready  (inst_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_bypass();
`ifdef LC3B_FETCH_BYPASS_EN
      return m_out && !m_stale && mem_resp && !redirect && (mq_inst.size() == 0);
`else
      return 1'b0;
`endif
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         bit byp;
         byp = m_bypass();
         check("mem_read", mem_read, m_out);
         check("mem_address", mem_address, m_out ? m_req : m_pc);
         check("inst_valid", inst_valid, (mq_inst.size() > 0) || byp);
         if (byp) begin
            check("inst_byp", inst, mem_rdata);
            check("inst_pc_byp", inst_pc, m_pc);
            check("opcode_byp", inst_opcode, mem_rdata[15:12]);
         end else if (mq_inst.size() > 0) begin
            check("inst", inst, mq_inst[0]);
            check("inst_pc", inst_pc, mq_pc[0]);
            check("opcode", inst_opcode, mq_inst[0][15:12]);
         end
      end
   end

   task automatic model_step();
      int n   = mq_inst.size();
      bit byp = m_bypass();
      bit pop = ((n > 0) || byp) && inst_ready;
      if (redirect) begin
         mq_inst.delete();
         mq_pc.delete();
         m_pc = redirect_pc & 16'hFFFE;
         if (m_out) begin
            if (mem_resp) begin m_out = 1'b0; m_stale = 1'b0; end
            else m_stale = 1'b1;
         end
      end else begin
         if (pop && n > 0) begin
            void'(mq_inst.pop_front());
            void'(mq_pc.pop_front());
         end
         if (m_out && mem_resp) begin
            if (!m_stale) begin
               if (!(byp && inst_ready)) begin
                  mq_inst.push_back(mem_rdata);
                  mq_pc.push_back(m_pc);
               end
               m_pc = m_pc + 16'd2;
            end
            m_out   = 1'b0;
            m_stale = 1'b0;
         end else if (!m_out && n < DEPTH) begin
            m_out   = 1'b1;
            m_req   = m_pc;
            m_stale = 1'b0;
         end
      end
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, release strobes.
   task automatic cyc(input bit resp, input lc3b_word rd, input bit rdr,
                      input lc3b_word rpc, input bit rdy);
      mem_resp    = resp;
      mem_rdata   = rd;
      redirect    = rdr;
      redirect_pc = rpc;
      inst_ready  = rdy;
      @(posedge clk);
      model_step();
      #1;
      mem_resp = 1'b0;
      redirect = 1'b0;
   endtask

   initial begin
      int waitc = 0;
      #12;
      check("rst_mem_read", mem_read, 1'b0);
      check("rst_mem_address", mem_address, 16'h3000);
      check("rst_inst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 16'h0000);
      check("rst_inst_pc", inst_pc, 16'h0000);
      check("rst_opcode", inst_opcode, op_br);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // First fetch, answered two cycles after the request.
      cyc(0, 0, 0, 0, 0);
      check("first_read", mem_read, 1'b1);
      check("first_addr", mem_address, 16'h3000);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 16'h1261, 0, 0, 0);
      check("t1_valid", inst_valid, 1'b1);
      check("t1_inst", inst, 16'h1261);
      check("t1_pc", inst_pc, 16'h3000);
      check("t1_opcode", inst_opcode, op_add);
      cyc(0, 0, 0, 0, 0);
      check("t1_next_addr", mem_address, 16'h3002);
      check("t1_next_read", mem_read, 1'b1);

      // Fill to DEPTH with the consumer stalled, then drain in order.
      cyc(1, 16'h5ABC, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0);
         check("full_no_read", mem_read, 1'b0);
      end
      check("full_head_pc", inst_pc, 16'h3000);
      cyc(0, 0, 0, 0, 1);
      check("drain_pc", inst_pc, 16'h3002);
      check("drain_inst", inst, 16'h5ABC);
      cyc(0, 0, 0, 0, 1);
      check("drain_empty", inst_valid, 1'b0);
      check("drain_addr", mem_address, 16'h3004);

      // Redirect while waiting on 3004: the stale read completes and is dropped.
      cyc(0, 0, 1, 16'h4001, 1);
      check("drop_read", mem_read, 1'b1);
      check("drop_addr", mem_address, 16'h3004);
      cyc(0, 0, 0, 0, 1);
      check("drop_addr_hold", mem_address, 16'h3004);
      cyc(1, 16'hDEAD, 0, 0, 1);
      check("drop_no_valid", inst_valid, 1'b0);
      check("drop_idle", mem_read, 1'b0);
      cyc(0, 0, 0, 0, 1);
      check("redir_addr", mem_address, 16'h4000);
      check("redir_read", mem_read, 1'b1);

      // Redirect coinciding with a response and a pop.
      cyc(1, 16'hBEEF, 0, 0, 0);
      check("t4_pc", inst_pc, 16'h4000);
      cyc(0, 0, 0, 0, 0);
      check("t4_addr", mem_address, 16'h4002);
      cyc(1, 16'h7777, 1, 16'h5000, 1);
      check("t4_flushed", inst_valid, 1'b0);
      check("t4_idle", mem_read, 1'b0);
      cyc(0, 0, 0, 0, 0);
      check("t4_target", mem_address, 16'h5000);

      // Address wrap at the top of memory.
      cyc(0, 0, 1, 16'hFFFF, 0);
      cyc(1, 16'h1111, 0, 0, 0);
      check("wrap_fetch_pc", mem_address, 16'hFFFE);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 16'hE123, 0, 0, 0);
      check("wrap_inst_pc", inst_pc, 16'hFFFE);
      check("wrap_next_addr", mem_address, 16'h0000);

      // Randomized traffic; the memory answers after 0..3 extra cycles.
      for (int i = 0; i < 4000; i++) begin
         bit r = 1'b0;
         if (mem_read) begin
            if (waitc == 0) begin
               r     = 1'b1;
               waitc = $urandom_range(0, 3);
            end else waitc--;
         end
         cyc(r, 16'($urandom), $urandom_range(0, 19) == 0, 16'($urandom),
             $urandom_range(0, 99) < (((i / 500) % 2) != 0 ? 80 : 20));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
